// File: rtl/alu_pkg.sv
// Shared constants for the ALU operand stage: MIPS field positions,
// opcode/funct encodings and writeback flag bit indices.
package alu_pkg;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_OVF  = 2;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;

    // The ALU sees its operands as pseudo-registers 0 (A) and 1 (B).
    localparam logic [4:0] RS_TAG = 5'd0;
    localparam logic [4:0] RT_TAG = 5'd1;

    function automatic logic [31:0] tag_operands(input logic [31:0] i);
        logic [31:0] r;
        r = i;
        r[RS_HI:RS_LO] = RS_TAG;
        r[RT_HI:RT_LO] = RT_TAG;
        return r;
    endfunction

endpackage

// File: rtl/alu_gpr_file.sv
// 32x32 general purpose register file: two async read ports, one write
// port, register 0 hardwired to zero.
module alu_gpr_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra_addr,
    output logic [31:0] ra_data,
    input  logic [4:0]  rb_addr,
    output logic [31:0] rb_data,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] regs [32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && wa != 5'd0) begin
            regs[wa] <= wd;
        end
    end

    assign ra_data = (ra_addr == 5'd0) ? 32'd0 : regs[ra_addr];
    assign rb_data = (rb_addr == 5'd0) ? 32'd0 : regs[rb_addr];

endmodule

// File: rtl/alu_operand_stage.sv
// Operand fetch stage: reads GPRs for the ALU behind a valid/ready
// register slice, with writeback bypass and sticky flag tracking.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int OVF_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [31:0]          out_regA,
    output logic [31:0]          out_regB,
    input  logic                 wb_en,
    input  logic [4:0]           wb_addr,
    input  logic [31:0]          wb_data,
    input  logic [2:0]           wb_flags,
    input  logic                 flags_clr,
    output logic [2:0]           sticky_flags,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  hold_rs;
    logic [4:0]  hold_rt;
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic        wr_ok;
    logic        cap;
    logic        ovf_ev;

    assign rs     = in_instr[RS_HI:RS_LO];
    assign rt     = in_instr[RT_HI:RT_LO];
    assign ovf_ev = wb_en && wb_flags[FLAG_OVF];
    assign wr_ok  = wb_en && !wb_flags[FLAG_OVF] && (wb_addr != 5'd0);

    assign in_ready = !out_valid || out_ready;
    assign cap      = in_valid && in_ready;

    alu_gpr_file u_gpr (
        .clk     (clk),
        .rst     (rst),
        .ra_addr (rs),
        .ra_data (rd_a),
        .rb_addr (rt),
        .rb_data (rd_b),
        .we      (wb_en && !wb_flags[FLAG_OVF]),
        .wa      (wb_addr),
        .wd      (wb_data)
    );

    // Held operands keep tracking writeback so a stalled ALU never
    // consumes a stale register value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_regA  <= '0;
            out_regB  <= '0;
            hold_rs   <= '0;
            hold_rt   <= '0;
        end else if (cap) begin
            out_valid <= 1'b1;
            out_instr <= tag_operands(in_instr);
            out_regA  <= (wr_ok && wb_addr == rs) ? wb_data : rd_a;
            out_regB  <= (wr_ok && wb_addr == rt) ? wb_data : rd_b;
            hold_rs   <= rs;
            hold_rt   <= rt;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end else if (out_valid) begin
            if (wr_ok && wb_addr == hold_rs) out_regA <= wb_data;
            if (wr_ok && wb_addr == hold_rt) out_regB <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_flags <= '0;
            ovf_count    <= '0;
        end else begin
            sticky_flags <= (flags_clr ? 3'b000 : sticky_flags)
                          | (wb_en ? wb_flags : 3'b000);
            if (ovf_ev && ovf_count != {OVF_CNT_W{1'b1}})
                ovf_count <= ovf_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage using directed vectors.
module tb_alu_operand_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_regA;
    logic [31:0] out_regB;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [2:0]  wb_flags;
    logic        flags_clr;
    logic [2:0]  sticky_flags;
    logic [7:0]  ovf_count;

    typedef struct packed {
        logic [31:0] i;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    alu_operand_stage #(.OVF_CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_regA     (out_regA),
        .out_regB     (out_regB),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .wb_flags     (wb_flags),
        .flags_clr    (flags_clr),
        .sticky_flags (sticky_flags),
        .ovf_count    (ovf_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mk(input logic [4:0] rs,
                                       input logic [4:0] rt,
                                       input logic [4:0] rd,
                                       input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic en, input logic [4:0] a,
                      input logic [31:0] d, input logic [2:0] f);
        wb_en    = en;
        wb_addr  = a;
        wb_data  = d;
        wb_flags = f;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] ei,
                         input logic [31:0] ea, input logic [31:0] eb);
        in_instr = ins;
        in_valid = 1'b1;
        sb.push_back('{i: ei, a: ea, b: eb});
    endtask

    // Monitor: every accepted output must match the head of the queue
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got %h/%h/%h expected none",
                             out_instr, out_regA, out_regB);
                end else begin
                    e = sb.pop_front();
                    if (out_instr !== e.i || out_regA !== e.a || out_regB !== e.b) begin
                        errors++;
                        $display("FAIL sb_out: got %h/%h/%h expected %h/%h/%h",
                                 out_instr, out_regA, out_regB, e.i, e.a, e.b);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b1;
        flags_clr = 1'b0;
        wb(0, 0, 0, 0);
        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_sticky", 32'(sticky_flags), 0);
        chk("rst_ovf", 32'(ovf_count), 0);
        tick;
        tick;
        rst = 1'b0;

        wb(1, 2, 32'd4, 3'b000);
        tick;
        wb(1, 3, 32'd5, 3'b000);
        tick;
        wb(0, 0, 0, 0);

        // basic add rs=2 rt=3
        issue(mk(2, 3, 4, 6'h20), mk(0, 1, 4, 6'h20), 32'd4, 32'd5);
        tick;
        in_valid = 1'b0;
        chk("latency_valid", 32'(out_valid), 1);
        chk("instr_fields", 32'(out_instr[25:16]), 32'h1);

        // capture with same-cycle write to rs
        issue(mk(2, 3, 5, 6'h20), mk(0, 1, 5, 6'h20), 32'h7FFFFFF8, 32'd5);
        wb(1, 2, 32'h7FFFFFF8, 3'b000);
        tick;
        in_valid = 1'b0;
        wb(0, 0, 0, 0);
        tick;

        // stall three cycles, update rt while held, offer next instr
        out_ready = 1'b0;
        issue(mk(2, 3, 6, 6'h22), mk(0, 1, 6, 6'h22), 32'h7FFFFFF8, 32'hFFFFFFD9);
        tick;
        issue(mk(3, 2, 7, 6'h25), mk(0, 1, 7, 6'h25), 32'hFFFFFFD9, 32'h7FFFFFF8);
        chk("stall_in_ready", 32'(in_ready), 0);
        wb(1, 3, 32'hFFFFFFD9, 3'b000);
        tick;
        wb(0, 0, 0, 0);
        tick;
        tick;
        chk("stall_regB", out_regB, 32'hFFFFFFD9);
        chk("stall_regA", out_regA, 32'h7FFFFFF8);
        chk("stall_instr", out_instr, mk(0, 1, 6, 6'h22));
        chk("stall_in_ready2", 32'(in_ready), 0);
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("xfer_cap_valid", 32'(out_valid), 1);
        tick;
        chk("drain_valid", 32'(out_valid), 0);

        // overflow writeback: suppressed write, counter and sticky
        wb(1, 4, 32'h80000007, 3'b100);
        tick;
        wb(0, 0, 0, 0);
        chk("ovf_count_1", 32'(ovf_count), 1);
        chk("ovf_sticky", 32'(sticky_flags), 32'h4);
        issue(mk(4, 0, 8, 6'h20), mk(0, 1, 8, 6'h20), 32'd0, 32'd0);
        tick;
        in_valid = 1'b0;
        wb(1, 4, 32'h80000007, 3'b100);
        repeat (299) tick;
        wb(0, 0, 0, 0);
        chk("ovf_saturate", 32'(ovf_count), 255);
        chk("ovf_sticky2", 32'(sticky_flags), 32'h4);

        // clear and set in the same cycle
        wb(1, 5, 32'd0, 3'b001);
        flags_clr = 1'b1;
        tick;
        flags_clr = 1'b0;
        wb(0, 0, 0, 0);
        chk("clr_set_sticky", 32'(sticky_flags), 32'h1);

        // write to R0 in the capture cycle must not bypass
        issue(mk(0, 2, 9, 6'h24), mk(0, 1, 9, 6'h24), 32'd0, 32'h7FFFFFF8);
        wb(1, 0, 32'h1234, 3'b000);
        tick;
        in_valid = 1'b0;
        wb(0, 0, 0, 0);
        issue(mk(0, 3, 10, 6'h20), mk(0, 1, 10, 6'h20), 32'd0, 32'hFFFFFFD9);
        tick;
        in_valid = 1'b0;
        tick;

        // asynchronous reset with an instruction held
        out_ready = 1'b0;
        issue(mk(2, 3, 11, 6'h20), mk(0, 1, 11, 6'h20), 32'h7FFFFFF8, 32'hFFFFFFD9);
        tick;
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_instr", out_instr, 0);
        chk("arst_regA", out_regA, 0);
        chk("arst_regB", out_regB, 0);
        chk("arst_in_ready", 32'(in_ready), 1);
        chk("arst_sticky", 32'(sticky_flags), 0);
        chk("arst_ovf", 32'(ovf_count), 0);
        sb.delete();
        tick;
        rst = 1'b0;
        out_ready = 1'b1;

        // GPRs cleared by reset
        issue(mk(2, 3, 12, 6'h20), mk(0, 1, 12, 6'h20), 32'd0, 32'd0);
        tick;
        in_valid = 1'b0;
        repeat (3) tick;
        chk("sb_drained", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 SHALL have parameter OVF_CNT_W, default 8, width of the saturating overflow counter.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, upstream instruction valid.
REQ-005 SHALL have port in_ready, output, 1, stage can accept an instruction.
REQ-006 SHALL have port in_instr, input, 32, MIPS instruction: op[31:26], rs[25:21], rt[20:16], funct[5:0].
REQ-007 SHALL have port out_valid, output, 1, ALU operands valid.
REQ-008 SHALL have port out_ready, input, 1, ALU consumer accepts.
REQ-009 SHALL have port out_instr, output, 32, instruction to ALU with rs field rewritten to 5'd0 and rt field to 5'd1.
REQ-010 SHALL have ports out_regA and out_regB, output, 32 each, GPR[rs] and GPR[rt].
REQ-011 SHALL have ports wb_en (1), wb_addr (5), wb_data (32), wb_flags (3, {ovf,neg,zero}), inputs, ALU result writeback.
REQ-012 SHALL have port flags_clr, input, 1, clears sticky flags.
REQ-013 SHALL have ports sticky_flags (3) and ovf_count (OVF_CNT_W), outputs.

Function
REQ-014 SHALL hold 32x32-bit GPR file; GPR[0] reads 0, writes to it ignored.
REQ-015 SHALL write GPR[wb_addr]=wb_data on a clk edge when wb_en=1 and wb_flags[2]=0; overflow suppresses the write.
REQ-016 SHALL assert in_ready = !out_valid || out_ready (combinational).
REQ-017 SHALL capture on in_valid && in_ready: out_instr, out_regA, out_regB registered, out_valid=1 next cycle; latency exactly 1 cycle.
REQ-018 SHALL bypass: if a suppression-free write in the capture cycle targets rs or rt (nonzero), the captured operand SHALL be wb_data.
REQ-019 SHALL, while out_valid && !out_ready, update held out_regA/out_regB when a suppression-free write targets the held rs/rt (nonzero); out_instr stable.
REQ-020 SHALL clear out_valid on out_ready when no new capture occurs in that cycle; transfer and capture in the same cycle SHALL leave out_valid=1 with new contents.
REQ-021 SHALL keep out_* stable while out_valid && !out_ready, except REQ-019.
REQ-022 SHALL update sticky_flags <= (flags_clr ? 0 : sticky_flags) | (wb_en ? wb_flags : 0); simultaneous clear and set yields the new flags.
REQ-023 SHALL increment ovf_count when wb_en && wb_flags[2], saturating at all-ones; no wrap.

Reset
REQ-024 SHALL on rst=1 immediately set out_valid=0, out_instr=0, out_regA=0, out_regB=0, sticky_flags=0, ovf_count=0, all GPRs=0.
REQ-025 SHALL drop an instruction held mid-transfer at reset; in_ready=1 during and after reset.

Structure
REQ-026 SHALL place opcode/funct constants, field bit positions and flag bit indices (ZERO=0, NEG=1, OVF=2) in shared package alu_pkg.
REQ-027 SHALL implement the GPR file as sub-module alu_gpr_file (two async read ports, one write port, R0 hardwired).

Verification
REQ-028 Write GPR[2]=4, GPR[3]=5; issue add rs=2,rt=3 -> next cycle out_valid=1, out_regA=4, out_regB=5, out_instr[25:16]=10'b00000_00001.
REQ-029 Capture add rs=2 while wb_en writes GPR[2]=0x7FFFFFF8 same cycle -> out_regA=0x7FFFFFF8.
REQ-030 Hold out_ready=0 three cycles, write GPR[3]=-39 meanwhile -> out_regB=0xFFFFFFD9, out_instr unchanged, in_ready=0.
REQ-031 wb_en, wb_addr=4, wb_data=0x80000007, wb_flags=3'b100 -> GPR[4] unchanged, ovf_count+1, sticky_flags[2]=1; 300 such events with OVF_CNT_W=8 -> ovf_count=255.
REQ-032 flags_clr with wb_flags=3'b001 same cycle -> sticky_flags=3'b001; write to GPR[0]=0x1234 -> reads 0.
REQ-033 Assert rst with out_valid=1 -> out_valid=0 and outputs 0 immediately, without clk edge.
